// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Screen codes, ROM selects, sequencer states and the
//               code-to-select mapping shared by the VGA screen sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam logic [31:0] SCR_SPLASH = 32'd0;
    localparam logic [31:0] SCR_DUMMY  = 32'd1;
    localparam logic [31:0] SCR_SL     = 32'd2;
    localparam logic [31:0] SCR_GAME   = 32'd4;

    localparam logic [1:0] SEL_SPLASH = 2'd0;
    localparam logic [1:0] SEL_DUMMY  = 2'd1;
    localparam logic [1:0] SEL_SL     = 2'd2;
    localparam logic [1:0] SEL_GAME   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] sel;
    } sel_res_t;

    function automatic sel_res_t code_to_sel(input logic [31:0] code);
        sel_res_t r;
        r.valid = 1'b1;
        r.sel   = SEL_SPLASH;
        case (code)
            SCR_SPLASH: r.sel = SEL_SPLASH;
            SCR_DUMMY:  r.sel = SEL_DUMMY;
            SCR_SL:     r.sel = SEL_SL;
            SCR_GAME:   r.sel = SEL_GAME;
            default:    r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_hl_arbiter.sv
// ============================================================================
// Module      : vga_hl_arbiter
// Description : Sticky lane-hit latch, strongest-level select and per-frame
//               hold counter for the lane highlight overlay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_hl_arbiter #(
    parameter int HOLD_FRAMES = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_start_i,
    input  logic       en_i,
    input  logic [2:0] hit_i,
    output logic [2:0] hl_o
);

    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_FRAMES - 1);

    logic [2:0] pend_q;
    logic [2:0] hl_q;
    logic [7:0] hcnt_q;
    logic [2:0] w_hits;
    logic [2:0] w_top;

    // Hits on the frame-start cycle itself belong to that frame start.
    always_comb begin
        w_hits = pend_q | hit_i;
        w_top  = 3'b000;
        if (w_hits[2])      w_top = 3'b100;
        else if (w_hits[1]) w_top = 3'b010;
        else if (w_hits[0]) w_top = 3'b001;
    end

    // One-hot codes order the same way as levels, so a plain compare works.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            pend_q <= 3'b000;
            hl_q   <= 3'b000;
            hcnt_q <= 8'd0;
        end else if (frame_start_i) begin
            pend_q <= 3'b000;
            if ((w_top != 3'b000) && (w_top >= hl_q)) begin
                hl_q   <= w_top;
                hcnt_q <= c_HOLD_LAST;
            end else if (hl_q != 3'b000) begin
                if (hcnt_q == 8'd0) hl_q   <= 3'b000;
                else                hcnt_q <= hcnt_q - 8'd1;
            end
        end else begin
            pend_q <= w_hits;
        end
    end

    assign hl_o = hl_q & {3{en_i}};

endmodule

`default_nettype wire

// File: rtl/vga_screen_sequencer.sv
// ============================================================================
// Module      : vga_screen_sequencer
// Description : Frame-synchronous background ROM sequencer with forced-blank
//               fade and lane-highlight overlay arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_screen_sequencer
    import vga_pkg::*;
#(
    parameter int FADE_FRAMES = 2,
    parameter int HOLD_FRAMES = 8
) (
    input  logic        iVGA_CLK,
    input  logic        iRST,
    input  logic        iVS,
    input  logic        iReqValid,
    input  logic [31:0] iScreenReq,
    output logic        oReqReady,
    output logic        oReqErr,
    output logic [1:0]  oScreenSel,
    output logic        oForceBlank,
    output logic        oSwitching,
    input  logic [2:0]  iHit,
    output logic [2:0]  oHighlight,
    output logic [15:0] oFrameCnt
);

    localparam logic [3:0] c_FADE_LAST = 4'((FADE_FRAMES == 0) ? 0 : FADE_FRAMES - 1);

    state_e      state_q;
    logic        vs_q;
    logic [1:0]  pend_sel_q;
    logic [3:0]  fcnt_q;
    logic [1:0]  sel_q;
    logic        blank_q;
    logic        sw_q;
    logic        ready_q;
    logic        err_q;
    logic [15:0] frame_q;

    logic        w_frame_start;
    logic        w_hl_en;
    sel_res_t    w_req;

    assign w_frame_start = vs_q & ~iVS;
    assign w_req         = code_to_sel(iScreenReq);
    assign w_hl_en       = (state_q == IDLE) && (sel_q == SEL_GAME);

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            vs_q       <= 1'b1;
            pend_sel_q <= SEL_SPLASH;
            fcnt_q     <= 4'd0;
            sel_q      <= SEL_SPLASH;
            blank_q    <= 1'b0;
            sw_q       <= 1'b0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            frame_q    <= 16'd0;
        end else begin
            vs_q  <= iVS;
            err_q <= 1'b0;
            if (w_frame_start) frame_q <= frame_q + 16'd1;

            case (state_q)
                IDLE: begin
                    if (iReqValid) begin
                        if (!w_req.valid) begin
                            err_q <= 1'b1;
                        end else if (w_req.sel != sel_q) begin
                            pend_sel_q <= w_req.sel;
                            state_q    <= PENDING;
                            sw_q       <= 1'b1;
                            ready_q    <= 1'b0;
                        end
                    end
                end
                PENDING: begin
                    if (w_frame_start) begin
                        if (FADE_FRAMES == 0) begin
                            sel_q   <= pend_sel_q;
                            sw_q    <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            blank_q <= 1'b1;
                            fcnt_q  <= c_FADE_LAST;
                            state_q <= BLANK;
                        end
                    end
                end
                BLANK: begin
                    if (w_frame_start) begin
                        if (fcnt_q == 4'd0) begin
                            sel_q   <= pend_sel_q;
                            blank_q <= 1'b0;
                            sw_q    <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            fcnt_q <= fcnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sw_q    <= 1'b0;
                    blank_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    vga_hl_arbiter #(
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_hl_arbiter (
        .clk_i         (iVGA_CLK),
        .rst_i         (iRST),
        .frame_start_i (w_frame_start),
        .en_i          (w_hl_en),
        .hit_i         (iHit),
        .hl_o          (oHighlight)
    );

    assign oReqReady   = ready_q;
    assign oReqErr     = err_q;
    assign oScreenSel  = sel_q;
    assign oForceBlank = blank_q;
    assign oSwitching  = sw_q;
    assign oFrameCnt   = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_screen_sequencer.sv
// ============================================================================
// Module      : tb_vga_screen_sequencer
// Description : Directed bench for the screen sequencer (FADE_FRAMES=2 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_screen_sequencer;

    logic        clk = 1'b0;
    logic        rst, vs, valid;
    logic [31:0] req;
    logic [2:0]  hit;
    logic        ready, err, blank, sw;
    logic [1:0]  sel;
    logic [2:0]  hl;
    logic [15:0] fcnt;

    logic        rst_b, vs_b, valid_b;
    logic [31:0] req_b;
    logic [2:0]  hit_b;
    logic        ready_b, err_b, blank_b, sw_b;
    logic [1:0]  sel_b;
    logic [2:0]  hl_b;
    logic [15:0] fcnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_screen_sequencer #(.FADE_FRAMES(2), .HOLD_FRAMES(8)) dut (
        .iVGA_CLK(clk), .iRST(rst), .iVS(vs), .iReqValid(valid), .iScreenReq(req),
        .oReqReady(ready), .oReqErr(err), .oScreenSel(sel), .oForceBlank(blank),
        .oSwitching(sw), .iHit(hit), .oHighlight(hl), .oFrameCnt(fcnt)
    );

    vga_screen_sequencer #(.FADE_FRAMES(0), .HOLD_FRAMES(8)) dut_b (
        .iVGA_CLK(clk), .iRST(rst_b), .iVS(vs_b), .iReqValid(valid_b), .iScreenReq(req_b),
        .oReqReady(ready_b), .oReqErr(err_b), .oScreenSel(sel_b), .oForceBlank(blank_b),
        .oSwitching(sw_b), .iHit(hit_b), .oHighlight(hl_b), .oFrameCnt(fcnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: falling edge of VS (with optional hit on that cycle), then VS high.
    task automatic do_frame(input logic [2:0] h);
        hit = h;
        vs  = 1'b0;
        tick();
        hit = 3'b000;
        vs  = 1'b1;
        tick();
    endtask

    task automatic request(input logic [31:0] code);
        valid = 1'b1;
        req   = code;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vs = 1'b1; valid = 1'b0; req = 32'd0; hit = 3'b000;
        rst_b = 1'b1; vs_b = 1'b1; valid_b = 1'b0; req_b = 32'd0; hit_b = 3'b000;
        tick();
        tick();
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_blank", 32'(blank), 32'd0);
        chk("rst_sw", 32'(sw), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_hl", 32'(hl), 32'd0);
        chk("rst_fcnt", 32'(fcnt), 32'd0);
        rst = 1'b0;
        rst_b = 1'b0;

        // Splash -> game with two blank frames
        request(32'd4);
        chk("acc_ready", 32'(ready), 32'd0);
        chk("acc_sw", 32'(sw), 32'd1);
        chk("acc_blank", 32'(blank), 32'd0);
        do_frame(3'b000);
        chk("f1_blank", 32'(blank), 32'd1);
        chk("f1_sel", 32'(sel), 32'd0);
        do_frame(3'b000);
        chk("f2_blank", 32'(blank), 32'd1);
        chk("f2_sel", 32'(sel), 32'd0);
        do_frame(3'b000);
        chk("f3_sel", 32'(sel), 32'd3);
        chk("f3_blank", 32'(blank), 32'd0);
        chk("f3_sw", 32'(sw), 32'd0);
        chk("f3_ready", 32'(ready), 32'd1);
        chk("f3_fcnt", 32'(fcnt), 32'd3);

        // Illegal codes
        request(32'd3);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_sel", 32'(sel), 32'd3);
        chk("err_ready", 32'(ready), 32'd1);
        chk("err_sw", 32'(sw), 32'd0);
        tick();
        chk("err_drop", 32'(err), 32'd0);
        request(32'h0000_0104);
        chk("err_wide", 32'(err), 32'd1);
        tick();

        // Highlight on game screen
        hit = 3'b001;
        tick();
        hit = 3'b000;
        do_frame(3'b000);
        chk("hl_001", 32'(hl), 32'b001);
        do_frame(3'b000);
        do_frame(3'b000);
        chk("hl_001_hold", 32'(hl), 32'b001);
        do_frame(3'b100);
        chk("hl_100_restart", 32'(hl), 32'b100);
        hit = 3'b010;
        tick();
        hit = 3'b000;
        do_frame(3'b000);
        chk("hl_010_ignored", 32'(hl), 32'b100);
        for (int i = 0; i < 6; i++) do_frame(3'b000);
        chk("hl_100_last", 32'(hl), 32'b100);
        do_frame(3'b000);
        chk("hl_100_clear", 32'(hl), 32'b000);

        // Request accepted on a frame-start cycle waits for the next one
        valid = 1'b1; req = 32'd2; vs = 1'b0;
        tick();
        valid = 1'b0; vs = 1'b1;
        tick();
        chk("same_fs_sw", 32'(sw), 32'd1);
        chk("same_fs_blank", 32'(blank), 32'd0);
        do_frame(3'b000);
        chk("same_fs_f1_blank", 32'(blank), 32'd1);
        do_frame(3'b000);
        chk("blank_sel", 32'(sel), 32'd3);
        chk("blank_fcnt", 32'(fcnt), 32'd18);

        // Reset during BLANK
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstb_sel", 32'(sel), 32'd0);
        chk("rstb_blank", 32'(blank), 32'd0);
        chk("rstb_sw", 32'(sw), 32'd0);
        chk("rstb_ready", 32'(ready), 32'd1);
        chk("rstb_fcnt", 32'(fcnt), 32'd0);

        // Same-screen request and hits on splash
        request(32'd0);
        chk("same_sw", 32'(sw), 32'd0);
        chk("same_ready", 32'(ready), 32'd1);
        chk("same_err", 32'(err), 32'd0);
        hit = 3'b111;
        tick();
        hit = 3'b000;
        do_frame(3'b000);
        chk("splash_hl", 32'(hl), 32'd0);
        chk("splash_blank", 32'(blank), 32'd0);

        // Hits during blank are not remembered
        request(32'd4);
        do_frame(3'b100);
        do_frame(3'b100);
        hit = 3'b100;
        tick();
        hit = 3'b000;
        do_frame(3'b000);
        chk("g2_sel", 32'(sel), 32'd3);
        chk("g2_hl", 32'(hl), 32'd0);
        do_frame(3'b000);
        chk("g2_hl_after", 32'(hl), 32'd0);
        hit = 3'b010;
        tick();
        hit = 3'b000;
        do_frame(3'b000);
        chk("g2_hl_010", 32'(hl), 32'b010);
        chk("g2_fcnt", 32'(fcnt), 32'd6);

        // Frame counter over a longer run
        for (int i = 0; i < 250; i++) do_frame(3'b000);
        chk("fcnt_256", 32'(fcnt), 32'd256);

        // FADE_FRAMES = 0 instance
        valid_b = 1'b1; req_b = 32'd2;
        tick();
        valid_b = 1'b0;
        chk("b_acc_sw", 32'(sw_b), 32'd1);
        chk("b_acc_sel", 32'(sel_b), 32'd0);
        vs_b = 1'b0;
        tick();
        vs_b = 1'b1;
        chk("b_sel", 32'(sel_b), 32'd2);
        chk("b_blank", 32'(blank_b), 32'd0);
        chk("b_sw", 32'(sw_b), 32'd0);
        chk("b_ready", 32'(ready_b), 32'd1);
        chk("b_fcnt", 32'(fcnt_b), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
